multicycle_ctrl_fsm: RTL and testbench

Sequencing controller for the multicycle RV32I datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath enable and mux select on each cycle. It handles the R-type, I-type ALU, load, store, branch, JAL and JALR opcode groups. It stalls on a single-ported memory with a ready handshake and traps on any other opcode.

---
 rtl/multicycle_ctrl_fsm.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Sequencing controller for the multicycle RV32I datapath: walks each instruction
// through fetch/decode/execute/memory/writeback and decodes every datapath control.
module multicycle_ctrl_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_TRAP     = 4'd15
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_e state_q, state_d;
    logic   illegal_q;

    // The branch decision (zero & pc_write_cond) is made in the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (run && mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADDR: state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_TRAP);
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        unique case (state_q)
            S_FETCH: if (run) begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 3'b010;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                alu_op    = 3'b011;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b10;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = 2'b01;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: expected control vectors are queued
// as each cycle's stimulus is driven and compared against the DUT mid-cycle.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst, run, zero, mem_ready;
    logic [6:0] opcode;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       instr_done, illegal;
    logic [3:0] state;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal;
        logic [3:0] state;
    } outs_t;

    outs_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    multicycle_ctrl_fsm dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic outs_t dut_outs();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done,
                illegal, state};
    endfunction

    // Control table for each state, written out from the controller description.
    function automatic outs_t exp_of(input int st, input bit r, input bit mr, input bit ill);
        outs_t e = '0;
        e.state   = st[3:0];
        e.illegal = ill;
        case (st)
            0:  if (r) begin e.mem_read = 1; e.alu_src_b = 2'b01; e.pc_write = mr; e.ir_write = mr; end
            1:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; end
            2:  begin e.alu_src_a = 2'b10; e.alu_op = 3'b010; end
            3:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b10; e.alu_op = 3'b011; end
            4:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b10; end
            5:  begin e.mem_read = 1; e.iord = 1; end
            6:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; e.instr_done = 1; end
            7:  begin e.mem_write = 1; e.iord = 1; e.instr_done = mr; end
            8:  begin e.reg_write = 1; e.instr_done = 1; end
            9:  begin e.alu_src_a = 2'b10; e.alu_op = 3'b001; e.pc_write_cond = 1;
                      e.pc_source = 2'b01; e.instr_done = 1; end
            10: begin e.pc_write = 1; e.pc_source = 2'b01; e.reg_write = 1;
                      e.mem_to_reg = 2'b10; e.instr_done = 1; end
            11: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b10; e.pc_write = 1;
                      e.reg_write = 1; e.mem_to_reg = 2'b10; e.instr_done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock cycle: drive inputs, queue the expectation, compare mid-cycle, advance.
    task automatic step(input string tag, input bit r, input bit mr, input logic [6:0] op,
                        input bit z, input int exp_st, input bit ill = 1'b0);
        outs_t e;
        run = r; mem_ready = mr; opcode = op; zero = z;
        exp_q.push_back(exp_of(exp_st, r, mr, ill));
        @(negedge clk);
        e = exp_q.pop_front();
        check($sformatf("%s_st%0d_state", tag, exp_st), 32'(state), 32'(e.state));
        check($sformatf("%s_st%0d_outs", tag, exp_st), 32'(dut_outs()), 32'(e));
        @(posedge clk);
        #1;
    endtask

    // Runs a whole instruction with mem_ready high; the state list ends at the retire state.
    task automatic run_instr(input string tag, input logic [6:0] op, input bit z,
                             input int s1, input int s2, input int s3);
        step(tag, 1, 1, op, z, 0);
        step(tag, 1, 1, op, z, 1);
        step(tag, 1, 1, op, z, s1);
        if (s2 >= 0) step(tag, 1, 1, op, z, s2);
        if (s3 >= 0) step(tag, 1, 1, op, z, s3);
    endtask

    initial begin
        rst = 1; run = 0; zero = 0; mem_ready = 0; opcode = '0;
        #2;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outs", 32'(dut_outs()), 32'(exp_of(0, 0, 0, 0)));
        @(posedge clk); #1;
        step("rst_hold", 0, 1, 7'b0110011, 0, 0);
        rst = 0;
        step("idle", 0, 1, 7'b0110011, 0, 0);
        step("idle", 0, 1, 7'b0110011, 0, 0);

        run_instr("rtype", 7'b0110011, 0, 2, 8, -1);
        run_instr("itype", 7'b0010011, 0, 3, 8, -1);

        // R-type with run dropped after fetch: must still complete.
        step("run_drop", 1, 1, 7'b0110011, 0, 0);
        step("run_drop", 0, 1, 7'b0110011, 0, 1);
        step("run_drop", 0, 1, 7'b0110011, 0, 2);
        step("run_drop", 0, 1, 7'b0110011, 0, 8);

        // Load with two stall cycles in MEM_RD.
        step("load", 1, 1, 7'b0000011, 0, 0);
        step("load", 1, 1, 7'b0000011, 0, 1);
        step("load", 1, 1, 7'b0000011, 0, 4);
        step("load", 1, 0, 7'b0000011, 0, 5);
        step("load", 1, 0, 7'b0000011, 0, 5);
        step("load", 1, 1, 7'b0000011, 0, 5);
        step("load", 1, 1, 7'b0000011, 0, 6);

        // Store with a fetch stall and a MEM_WR stall.
        step("store", 1, 0, 7'b0100011, 0, 0);
        step("store", 1, 1, 7'b0100011, 0, 0);
        step("store", 1, 1, 7'b0100011, 0, 1);
        step("store", 1, 1, 7'b0100011, 0, 4);
        step("store", 1, 0, 7'b0100011, 0, 7);
        step("store", 1, 1, 7'b0100011, 0, 7);

        run_instr("beq_taken", 7'b1100011, 1, 9, -1, -1);
        run_instr("beq_not", 7'b1100011, 0, 9, -1, -1);
        run_instr("jal", 7'b1101111, 0, 10, -1, -1);
        run_instr("jalr", 7'b1100111, 0, 11, -1, -1);
        run_instr("store_fast", 7'b0100011, 0, 4, 7, -1);

        // Reset in the middle of a MEM_WR stall aborts without a retire pulse.
        step("abort", 1, 1, 7'b0100011, 0, 0);
        step("abort", 1, 1, 7'b0100011, 0, 1);
        step("abort", 1, 1, 7'b0100011, 0, 4);
        step("abort", 1, 0, 7'b0100011, 0, 7);
        #1;
        check("abort_pre_mem_write", 32'(mem_write), 32'd1);
        rst = 1;
        #1;
        check("abort_state", 32'(state), 32'd0);
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_instr_done", 32'(instr_done), 32'd0);
        @(posedge clk); #1;
        step("abort_rst", 0, 0, 7'b0100011, 0, 0);
        rst = 0;
        step("abort_idle", 0, 1, 7'b0100011, 0, 0);

        // Illegal opcode traps and holds until reset.
        step("trap", 1, 1, 7'b1111111, 0, 0);
        step("trap", 1, 1, 7'b1111111, 0, 1);
        for (int i = 0; i < 11; i++)
            step("trap", 1, 1, 7'(i * 13), 1, 15, 1'b1);
        rst = 1;
        #1;
        check("trap_rst_state", 32'(state), 32'd0);
        check("trap_rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        run_instr("post_trap", 7'b0110011, 0, 2, 8, -1);
        step("final_idle", 0, 1, 7'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
